bit_deserializer: RTL and testbench

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

---
 rtl/bit_deserializer_if.sv | 26 ++
 rtl/bit_deserializer.sv | 83 ++++++++
 tb/tb_bit_deserializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bit_deserializer_if.sv
// Serial-bit in / assembled-word out bundle for bit_deserializer.
// master drives bits and downstream ready; slave returns the registered word side.
interface bit_deserializer_if #(
  parameter int N = 8
) ();
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  logic          bit_in;
  logic          bit_valid;
  logic          flush;
  logic          word_ready;
  logic [N-1:0]  word_out;
  logic          word_valid;
  logic [CW-1:0] bit_count;
  logic          overrun;

  modport master (
    output bit_in, bit_valid, flush, word_ready,
    input  word_out, word_valid, bit_count, overrun
  );

  modport slave (
    input  bit_in, bit_valid, flush, word_ready,
    output word_out, word_valid, bit_count, overrun
  );
endinterface

// File: rtl/bit_deserializer.sv
// Shifts serial bits into N-bit words; word registered 1 cycle after the completing bit.
// Single output slot: completion while full and not ready drops the word and sets sticky overrun.
module bit_deserializer #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  bit_deserializer_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t    state_q, state_d;
  logic [N-1:0]  shift_q, next_shift;
  logic [N-1:0]  word_q, word_d;
  logic [CW-1:0] count_q;
  logic          overrun_q, overrun_d;
  logic          take, complete;

  always_comb begin
    take     = bus.bit_valid && !bus.flush;
    complete = take && (count_q == CW'(N - 1));
    if (MSB_FIRST != 0) next_shift = {shift_q[N-2:0], bus.bit_in};
    else                next_shift = {bus.bit_in, shift_q[N-1:1]};
  end

  // Collect side: flush wins over bit_valid; count wraps on completion.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (bus.bit_valid) begin
      shift_q <= next_shift;
      count_q <= complete ? '0 : count_q + CW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    overrun_d = overrun_q;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          word_d  = next_shift;
        end
      end
      FULL: begin
        if (complete && bus.word_ready) begin
          word_d = next_shift;
        end else if (complete) begin
          overrun_d = 1'b1;
        end else if (bus.word_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= EMPTY;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = (state_q == FULL);
  assign bus.bit_count  = count_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_bit_deserializer.sv
// Drives MSB-first and LSB-first deserializers with the same bit stream and checks both
// against a queue-based word model every cycle, plus literal expectations at key points.
module tb_bit_deserializer;
  localparam int N = 8;

  logic clk = 1'b0;
  logic n_reset, bit_in, bit_valid, flush, word_ready;
  always #5 clk = ~clk;

  bit_deserializer_if #(.N(N)) ifm ();
  bit_deserializer_if #(.N(N)) ifl ();

  assign ifm.bit_in = bit_in;   assign ifl.bit_in = bit_in;
  assign ifm.bit_valid = bit_valid; assign ifl.bit_valid = bit_valid;
  assign ifm.flush = flush;     assign ifl.flush = flush;
  assign ifm.word_ready = word_ready; assign ifl.word_ready = word_ready;

  bit_deserializer #(.N(N), .MSB_FIRST(1)) dut_m (.clk(clk), .n_reset(n_reset), .bus(ifm));
  bit_deserializer #(.N(N), .MSB_FIRST(0)) dut_l (.clk(clk), .n_reset(n_reset), .bus(ifl));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Model: bits received so far in arrival order; a word is formed when N have arrived.
  bit           q_bits[$];
  logic [N-1:0] exp_wm = '0, exp_wl = '0;
  bit           exp_valid = 1'b0, exp_ovr = 1'b0;

  always @(posedge clk) begin
    bit           consume, done;
    logic [N-1:0] wm, wl;
    if (!n_reset) begin
      q_bits.delete();
      exp_wm = '0; exp_wl = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
    end else begin
      consume = exp_valid && word_ready;
      done    = 1'b0;
      wm = '0; wl = '0;
      if (flush) q_bits.delete();
      else if (bit_valid) begin
        q_bits.push_back(bit_in);
        if (q_bits.size() == N) begin
          for (int i = 0; i < N; i++) begin
            wm[N-1-i] = q_bits[i];
            wl[i]     = q_bits[i];
          end
          q_bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!exp_valid || consume) begin
          exp_wm = wm; exp_wl = wl; exp_valid = 1'b1;
        end else exp_ovr = 1'b1;
      end else if (consume) exp_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m.word_out",   32'(ifm.word_out),   32'(exp_wm));
      cmp("m.word_valid", 32'(ifm.word_valid), 32'(exp_valid));
      cmp("m.bit_count",  32'(ifm.bit_count),  32'(q_bits.size()));
      cmp("m.overrun",    32'(ifm.overrun),    32'(exp_ovr));
      cmp("l.word_out",   32'(ifl.word_out),   32'(exp_wl));
      cmp("l.word_valid", 32'(ifl.word_valid), 32'(exp_valid));
      cmp("l.bit_count",  32'(ifl.bit_count),  32'(q_bits.size()));
      cmp("l.overrun",    32'(ifl.overrun),    32'(exp_ovr));
    end
  end

  task automatic step(input logic rn, input logic bv, input logic b, input logic fl, input logic rdy);
    n_reset = rn; bit_valid = bv; bit_in = b; flush = fl; word_ready = rdy;
    @(negedge clk);
  endtask

  // Bits go out W[7] first, so the MSB-first instance rebuilds W and the other its bit-reverse.
  task automatic send_word(input logic [7:0] w, input logic rdy_other, input logic rdy_last,
                           input bit gaps);
    for (int i = N - 1; i >= 0; i--) begin
      step(1'b1, 1'b1, w[i], 1'b0, (i == 0) ? rdy_last : rdy_other);
      if (gaps && i != 0) step(1'b1, 1'b0, 1'b0, 1'b0, rdy_other);
    end
  endtask

  initial begin
    logic [7:0] w5;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_on = 1'b1;
    cmp("rst.word_out",   32'(ifm.word_out),   32'h0);
    cmp("rst.word_valid", 32'(ifm.word_valid), 32'h0);
    cmp("rst.bit_count",  32'(ifm.bit_count),  32'h0);
    cmp("rst.overrun",    32'(ifm.overrun),    32'h0);

    // A5 with ready high: one-cycle valid pulse, same value in both bit orders.
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    cmp("a5.m_word",  32'(ifm.word_out),   32'hA5);
    cmp("a5.l_word",  32'(ifl.word_out),   32'hA5);
    cmp("a5.valid",   32'(ifm.word_valid), 32'h1);
    cmp("a5.count",   32'(ifm.bit_count),  32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("a5.pulse_end", 32'(ifm.word_valid), 32'h0);

    // Overrun: 3C held, FF dropped.
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    cmp("ovr.word",    32'(ifm.word_out),   32'h3C);
    cmp("ovr.valid",   32'(ifm.word_valid), 32'h1);
    cmp("ovr.flag",    32'(ifm.overrun),    32'h1);
    cmp("ovr.count",   32'(ifm.bit_count),  32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("ovr.sticky",  32'(ifm.overrun),    32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("ovr.rst_flag",  32'(ifm.overrun),    32'h0);
    cmp("ovr.rst_valid", 32'(ifm.word_valid), 32'h0);

    // Consume on exactly the completing edge of the next word.
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1, 1'b0);
    cmp("sim.valid",  32'(ifm.word_valid), 32'h1);
    cmp("sim.m_word", 32'(ifm.word_out),   32'h22);
    cmp("sim.l_word", 32'(ifl.word_out),   32'h44);
    cmp("sim.ovr",    32'(ifm.overrun),    32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Partial word flushed (bit_valid high on the flush edge is ignored), then gapped 5A.
    w5 = 8'b10110;
    for (int i = 4; i >= 0; i--) step(1'b1, 1'b1, w5[i], 1'b0, 1'b0);
    cmp("fl.partial", 32'(ifm.bit_count), 32'h5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cmp("fl.count",   32'(ifm.bit_count), 32'h0);
    send_word(8'h5A, 1'b0, 1'b0, 1'b1);
    cmp("fl.m_word",  32'(ifm.word_out), 32'h5A);
    cmp("fl.l_word",  32'(ifl.word_out), 32'h5A);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cmp("fl.consume", 32'(ifm.word_valid), 32'h0);
    cmp("fl.hold",    32'(ifm.word_out),   32'h5A);

    // Reset mid-word, then C3; nothing valid until the 8th post-reset bit.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'(i & 1), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    w5 = 8'hC3;
    for (int i = N - 1; i >= 1; i--) step(1'b1, 1'b1, w5[i], 1'b0, 1'b0);
    cmp("rm.no_early", 32'(ifm.word_valid), 32'h0);
    step(1'b1, 1'b1, w5[0], 1'b0, 1'b0);
    cmp("rm.valid",   32'(ifm.word_valid), 32'h1);
    cmp("rm.m_word",  32'(ifm.word_out),   32'hC3);
    cmp("rm.l_word",  32'(ifl.word_out),   32'hC3);

    // Reset while full drops the held word.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("rf.valid", 32'(ifm.word_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
